// File: rtl/aud_dac_feeder.sv
// aud_dac_feeder: PCM sample FIFO feeding the I2S DAC serializer, one sample per LR half-frame.
// Pops on LR edges preload o_dac_data one bclk ahead of the next half-frame capture.
module aud_dac_feeder #(
  parameter int DEPTH = 8,
  parameter int DW = 16
) (
  input  logic                     i_bclk,
  input  logic                     i_rst_n,
  input  logic                     i_daclrck,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic                     i_mono,
  input  logic                     i_wr_valid,
  input  logic [DW-1:0]            i_wr_data,
  output logic                     o_wr_ready,
  output logic [DW-1:0]            o_dac_data,
  output logic                     o_underflow,
  output logic [7:0]               o_underflow_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_lrclk;
  logic          w_full, w_empty, w_edge, w_fall, w_pop_req, w_push;
  assign w_empty    = r_wr_ptr == r_rd_ptr;
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_edge     = i_daclrck ^ r_lrclk;
  assign w_fall     = r_lrclk & ~i_daclrck;
  assign w_pop_req  = i_en & ~i_flush & (i_mono ? w_fall : w_edge);
  assign o_wr_ready = ~w_full & ~i_flush;
  assign w_push     = i_wr_valid & o_wr_ready;
  assign o_level    = r_wr_ptr - r_rd_ptr;
  always_ff @(posedge i_bclk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_lrclk         <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      o_dac_data      <= '0;
      o_underflow     <= 1'b0;
      o_underflow_cnt <= '0;
    end else begin
      r_lrclk     <= i_daclrck;
      o_underflow <= 1'b0;
      if (i_flush) begin
        r_wr_ptr        <= '0;
        r_rd_ptr        <= '0;
        o_dac_data      <= '0;
        o_underflow_cnt <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        // An empty pop plays silence; a same-cycle push is only stored, never bypassed
        if (w_pop_req) begin
          if (w_empty) begin
            o_dac_data      <= '0;
            o_underflow     <= 1'b1;
            o_underflow_cnt <= o_underflow_cnt + {7'd0, o_underflow_cnt != 8'hFF};
          end else begin
            o_dac_data <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
          end
        end else if (!i_en) o_dac_data <= '0;
      end
    end
  always_ff @(posedge i_bclk)
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
endmodule

// File: tb/tb_aud_dac_feeder.sv
// tb_aud_dac_feeder: vector table, corner sequences and random traffic against a queue model.
module tb_aud_dac_feeder;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lr = 1'b0, en = 1'b0, fl = 1'b0, mono = 1'b0, v = 1'b0;
  logic [15:0] d = '0;
  logic o_wr_ready, o_underflow;
  logic [15:0] o_dac_data;
  logic [7:0] o_underflow_cnt;
  logic [3:0] o_level;
  int checks = 0, errors = 0;
  logic [15:0] mq [$];
  logic m_lr = 1'b0, m_uf = 1'b0, s_rdy;
  logic [15:0] m_dac = '0;
  int m_cnt = 0;
  typedef struct { int v, d, en, mono, fl, lr, rdy, dac, lvl, uf, cnt; } vec_t;
  vec_t tbl [29];

  aud_dac_feeder #(.DEPTH(DEPTH), .DW(16)) dut (
    .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lr), .i_en(en), .i_flush(fl),
    .i_mono(mono), .i_wr_valid(v), .i_wr_data(d), .o_wr_ready(o_wr_ready),
    .o_dac_data(o_dac_data), .o_underflow(o_underflow),
    .o_underflow_cnt(o_underflow_cnt), .o_level(o_level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lr = 1'b0; m_uf = 1'b0; m_dac = '0; m_cnt = 0;
  endtask

  task automatic step();
    logic rdy, edg, fall, pop;
    #1;
    rdy = (mq.size() < DEPTH) && !fl;
    s_rdy = o_wr_ready;
    chk("ready", o_wr_ready, rdy);
    edg = lr != m_lr;
    fall = m_lr && !lr;
    pop = en && !fl && (mono ? fall : edg);
    m_uf = 1'b0;
    if (fl) begin
      mq.delete(); m_dac = '0; m_cnt = 0;
    end else begin
      if (pop) begin
        if (mq.size() == 0) begin
          m_dac = '0; m_uf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else m_dac = mq.pop_front();
      end else if (!en) m_dac = '0;
      if (v && rdy) mq.push_back(d);
    end
    m_lr = lr;
    @(posedge clk); #1;
    chk("dac", o_dac_data, m_dac);
    chk("underflow", o_underflow, m_uf);
    chk("uf_cnt", o_underflow_cnt, m_cnt);
    chk("level", o_level, mq.size());
  endtask

  initial begin
    tbl = '{
      '{1,'h1111,1,0,0,0, 1,'h0000,1,0,0},
      '{1,'h2222,1,0,0,0, 1,'h0000,2,0,0},
      '{1,'h3333,1,0,0,0, 1,'h0000,3,0,0},
      '{1,'h4444,1,0,0,0, 1,'h0000,4,0,0},
      '{0,0,1,0,0,1, 1,'h1111,3,0,0},
      '{0,0,1,0,0,1, 1,'h1111,3,0,0},
      '{0,0,1,0,0,0, 1,'h2222,2,0,0},
      '{0,0,1,0,0,1, 1,'h3333,1,0,0},
      '{0,0,1,0,0,0, 1,'h4444,0,0,0},
      '{0,0,1,0,0,1, 1,0,0,1,1},
      '{0,0,1,0,0,1, 1,0,0,0,1},
      '{0,0,1,0,0,0, 1,0,0,1,2},
      '{0,0,1,0,0,1, 1,0,0,1,3},
      '{0,0,1,0,0,1, 1,0,0,0,3},
      '{1,'hAAAA,1,1,0,1, 1,0,1,0,3},
      '{1,'h5555,1,1,0,1, 1,0,2,0,3},
      '{0,0,1,1,0,0, 1,'hAAAA,1,0,3},
      '{0,0,1,1,0,1, 1,'hAAAA,1,0,3},
      '{0,0,1,1,0,0, 1,'h5555,0,0,3},
      '{0,0,1,1,0,1, 1,'h5555,0,0,3},
      '{1,'h0A01,1,0,0,1, 1,'h5555,1,0,3},
      '{1,'h0A02,1,0,0,1, 1,'h5555,2,0,3},
      '{1,'h0A03,1,0,0,1, 1,'h5555,3,0,3},
      '{1,'h0A04,1,0,0,1, 1,'h5555,4,0,3},
      '{1,'h0A05,1,0,0,1, 1,'h5555,5,0,3},
      '{1,'hBEEF,1,0,1,0, 0,0,0,0,0},
      '{1,'h7FFF,1,0,0,1, 1,0,1,1,1},
      '{0,0,1,0,0,0, 1,'h7FFF,0,0,1},
      '{0,0,0,0,0,0, 1,0,0,0,1}};
    #1;
    chk("rst_dac", o_dac_data, 0);
    chk("rst_level", o_level, 0);
    chk("rst_ready", o_wr_ready, 1);
    chk("rst_cnt", o_underflow_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 29; i++) begin
      v = 1'(tbl[i].v); d = 16'(tbl[i].d); en = 1'(tbl[i].en);
      mono = 1'(tbl[i].mono); fl = 1'(tbl[i].fl); lr = 1'(tbl[i].lr);
      step();
      chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_dac", i), o_dac_data, tbl[i].dac);
      chk($sformatf("tbl%0d_level", i), o_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_uf", i), o_underflow, tbl[i].uf);
      chk($sformatf("tbl%0d_cnt", i), o_underflow_cnt, tbl[i].cnt);
    end
    // backpressure with playback paused
    v = 1'b0; fl = 1'b1; step(); fl = 1'b0;
    en = 1'b0; mono = 1'b0; v = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = 16'hC000 + 16'(i);
      step();
    end
    chk("bp_level", o_level, DEPTH);
    chk("bp_ready", o_wr_ready, 0);
    en = 1'b1; lr = ~lr; d = 16'hC0FF;
    step();
    chk("bp_pop_dac", o_dac_data, 16'hC000);
    chk("bp_pop_level", o_level, DEPTH - 1);
    step();
    chk("bp_ready_back", s_rdy, 1);
    chk("bp_refill", o_level, DEPTH);
    // underflow counter saturation
    v = 1'b0; fl = 1'b1; step(); fl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      lr = ~lr;
      step();
    end
    chk("sat_cnt", o_underflow_cnt, 255);
    // randomized traffic
    begin
      int per = 2, cnt = 0;
      for (int i = 0; i < 3000; i++) begin
        v = 1'($urandom % 2); d = 16'($urandom);
        en = ($urandom % 16) != 0; fl = ($urandom % 64) == 0;
        if ($urandom % 200 == 0) mono = ~mono;
        if (++cnt >= per) begin
          lr = ~lr; cnt = 0; per = $urandom_range(1, 6);
        end
        step();
      end
    end
    // asynchronous reset mid-stream, no clock edge needed
    v = 1'b1; fl = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin d = 16'h1234 + 16'(i); step(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac", o_dac_data, 0);
    chk("arst_level", o_level, 0);
    chk("arst_ready", o_wr_ready, 1);
    chk("arst_cnt", o_underflow_cnt, 0);
    chk("arst_uf", o_underflow, 0);
    @(posedge clk); #1;
    lr = 1'b0; v = 1'b0; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom % 2); d = 16'($urandom);
      if (i % 3 == 0) lr = ~lr;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aud_dac_feeder.md
Name: aud_dac_feeder

Overview:
Sample buffer that sits directly upstream of the I2S DAC serializer, in the i_bclk domain. It accepts 16-bit PCM samples from the DSP stage through a valid/ready handshake and stores them in a small FIFO. It presents one stable sample on o_dac_data per DAC LR half-frame, preloaded ahead of the serializer's capture edge. It also handles mono duplication, underflow reporting and flush.

Parameters:
DEPTH, 8, FIFO depth in samples; power of 2, minimum 2
DW, 16, sample width; fixed to 16 for this codec

Ports:
i_bclk  in  1  bit clock; all logic on posedge
i_rst_n  in  1  reset, asynchronous, active-low
i_daclrck  in  1  DAC LR clock, already synchronous to i_bclk
i_en  in  1  playback enable; pops occur only while high
i_flush  in  1  synchronous FIFO clear
i_mono  in  1  1: each sample feeds both L and R; 0: interleaved L/R stream
i_wr_valid  in  1  upstream sample valid
i_wr_data  in  DW  upstream sample, two's complement
o_wr_ready  out  1  FIFO can accept a sample this cycle
o_dac_data  out  DW  sample for the next half-frame; to serializer i_dac_data
o_underflow  out  1  one-cycle pulse when a pop hits an empty FIFO
o_underflow_cnt  out  8  saturating underflow count
o_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset values: o_dac_data=0, o_underflow=0, o_underflow_cnt=0, o_level=0, FIFO empty, rd/wr pointers=0, lrclk_r=0.
- lrclk_r <= i_daclrck every cycle, with no freeze.
- edge = i_daclrck ^ lrclk_r; fall = lrclk_r & ~i_daclrck.
- Push: i_wr_valid & o_wr_ready at posedge stores i_wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
- o_wr_ready = ~full & ~i_flush, combinational.
- pop_req = i_en & ~i_flush & (i_mono ? fall : edge).
- Pop with non-empty FIFO: o_dac_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Pop with empty FIFO: o_dac_data <= 0; o_underflow=1 for that cycle; o_underflow_cnt increments, saturating at 255.
- Preload timing: the serializer captures o_dac_data on the same posedge that it detects the LR edge. The new value written by the pop applies to the following half-frame. Latency from LR edge to new o_dac_data is 1 bclk.
- Mono mode: rising LR edges cause no pop, and o_dac_data holds, so one sample plays in both halves.
- i_en low: no pops; o_dac_data <= 0 on the next posedge; FIFO contents retained; push still allowed.
- i_flush high: pointers and o_level go to 0, o_dac_data <= 0, o_underflow_cnt <= 0. Any push that cycle is refused (ready is low). Flush has priority over push and pop.
- Simultaneous push and pop with non-empty FIFO: both happen; o_level unchanged.
- Simultaneous push and pop with empty FIFO: no bypass. The pop underflows (outputs 0) and the push is stored; o_level becomes 1.
- Full FIFO: ready is low even if a pop occurs that cycle, so no push happens that cycle.
- Pointers carry one extra wrap bit. full = (ptr MSB differs) & (lower bits equal); empty = pointers equal.
- o_level = wr_ptr - rd_ptr, using the extended width.
- Asynchronous reset mid-stream returns everything to the reset values immediately; no partial state is preserved.

Test Plan:
- Reset: assert i_rst_n=0 mid-operation → o_dac_data=0, o_level=0, o_wr_ready=1, o_underflow_cnt=0 with no clock needed.
- Stereo stream: push 0x1111, 0x2222, 0x3333, 0x4444; i_en=1, i_mono=0; toggle i_daclrck every 32 bclk → o_dac_data shows 0x1111, 0x2222, 0x3333, 0x4444 on successive edges, each 1 bclk after the edge; o_level goes 4→0.
- Mono: i_mono=1; push 0xAAAA, 0x5555; four LR edges starting with a fall → o_dac_data is 0xAAAA for two half-frames, then 0x5555; pops occur only on falling edges.
- Underflow: empty FIFO with i_en=1; three LR edges → o_dac_data=0, three o_underflow pulses, o_underflow_cnt=3.
- Underflow saturation: 300 empty pops → o_underflow_cnt=255.
- Backpressure: with i_en=0, push DEPTH+2 samples with valid held high → o_wr_ready=0 after 8 pushes, o_level=8, extra samples not accepted. Then one pop → ready returns the next cycle and the next push is accepted.
- Flush and simultaneous events: o_level=5, assert i_flush during an LR edge with i_wr_valid=1 → o_level=0, o_dac_data=0, no push. Separately, empty FIFO with push 0x7FFF and pop in the same cycle → underflow pulse, o_dac_data=0, o_level=1, and the next pop yields 0x7FFF.
